// File: rtl/decode_aligner_pkg.sv
// decode_aligner_pkg: RV32 opcode, RVC quadrant/funct3 constants and instruction encoders
package decode_aligner_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;
  localparam logic [2:0] C3_ADDI4SPN = 3'b000;
  localparam logic [2:0] C3_LW       = 3'b010;
  localparam logic [2:0] C3_SW       = 3'b110;
  localparam logic [2:0] C3_ADDI     = 3'b000;
  localparam logic [2:0] C3_JAL      = 3'b001;
  localparam logic [2:0] C3_LI       = 3'b010;
  localparam logic [2:0] C3_LUI      = 3'b011;
  localparam logic [2:0] C3_MISC_ALU = 3'b100;
  localparam logic [2:0] C3_J        = 3'b101;
  localparam logic [2:0] C3_BEQZ     = 3'b110;
  localparam logic [2:0] C3_BNEZ     = 3'b111;
  localparam logic [2:0] C3_SLLI     = 3'b000;
  localparam logic [2:0] C3_LWSP     = 3'b010;
  localparam logic [2:0] C3_JR_MV    = 3'b100;
  localparam logic [2:0] C3_SWSP     = 3'b110;
  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction
  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
endpackage

// File: rtl/decode_aligner_rvc_expander.sv
// rvc_expander: combinational RV32C halfword to RV32I instruction expansion with illegal detect
module rvc_expander
  import decode_aligner_pkg::*;
(
  input  logic [15:0] i_c,
  output logic [31:0] o_inst,
  output logic        o_illegal
);
  logic [4:0] rd, rs2, rp_lo, rp_hi;
  logic [11:0] imm6, lw_imm, a4_imm, a16_imm, lwsp_imm, swsp_imm;
  logic [20:1] j_imm;
  logic [12:1] b_imm;
  logic [2:0] alu_f3;
  logic [31:0] exp;
  logic ill;
  assign rd       = i_c[11:7];
  assign rs2      = i_c[6:2];
  assign rp_lo    = {2'b01, i_c[4:2]};
  assign rp_hi    = {2'b01, i_c[9:7]};
  assign imm6     = {{7{i_c[12]}}, i_c[6:2]};
  assign lw_imm   = {5'b0, i_c[5], i_c[12:10], i_c[6], 2'b00};
  assign a4_imm   = {2'b00, i_c[10:7], i_c[12:11], i_c[5], i_c[6], 2'b00};
  assign a16_imm  = {{3{i_c[12]}}, i_c[4:3], i_c[5], i_c[2], i_c[6], 4'b0};
  assign lwsp_imm = {4'b0, i_c[3:2], i_c[12], i_c[6:4], 2'b00};
  assign swsp_imm = {4'b0, i_c[8:7], i_c[12:9], 2'b00};
  assign j_imm    = {{10{i_c[12]}}, i_c[8], i_c[10:9], i_c[6], i_c[7], i_c[2], i_c[11], i_c[5:3]};
  assign b_imm    = {{5{i_c[12]}}, i_c[6:5], i_c[2], i_c[11:10], i_c[4:3]};
  assign alu_f3   = (i_c[6:5] == 2'b00) ? 3'b000 : {1'b1, i_c[6], i_c[6] & i_c[5]};
  always_comb begin
    exp = '0;
    ill = 1'b0;
    case ({i_c[1:0], i_c[15:13]})
      {Q0, C3_ADDI4SPN}: begin
        ill = (a4_imm == '0);
        exp = i_type(a4_imm, 5'd2, 3'b000, rp_lo, OPC_OP_IMM);
      end
      {Q0, C3_LW}:       exp = i_type(lw_imm, rp_hi, 3'b010, rp_lo, OPC_LOAD);
      {Q0, C3_SW}:       exp = s_type(lw_imm, rp_lo, rp_hi, 3'b010, OPC_STORE);
      {Q1, C3_ADDI}:     exp = i_type(imm6, rd, 3'b000, rd, OPC_OP_IMM);
      {Q1, C3_JAL}, {Q1, C3_J}:
        exp = {j_imm[20], j_imm[10:1], j_imm[11], j_imm[19:12], i_c[15] ? 5'd0 : 5'd1, OPC_JAL};
      {Q1, C3_LI}:       exp = i_type(imm6, 5'd0, 3'b000, rd, OPC_OP_IMM);
      {Q1, C3_LUI}: begin
        ill = ({i_c[12], i_c[6:2]} == 6'd0);
        exp = (rd == 5'd2) ? i_type(a16_imm, 5'd2, 3'b000, 5'd2, OPC_OP_IMM)
                           : {{15{i_c[12]}}, i_c[6:2], rd, OPC_LUI};
      end
      {Q1, C3_MISC_ALU}: begin
        ill = i_c[12] && (i_c[11:10] != 2'b10);
        exp = (i_c[11:10] == 2'b10) ? i_type(imm6, rp_hi, 3'b111, rp_hi, OPC_OP_IMM)
            : (i_c[11:10] == 2'b11) ? r_type((i_c[6:5] == 2'b00) ? 7'b0100000 : 7'b0, rp_lo, rp_hi, alu_f3, rp_hi, OPC_OP)
            : r_type({1'b0, i_c[10], 5'b0}, rs2, rp_hi, 3'b101, rp_hi, OPC_OP_IMM);
      end
      {Q1, C3_BEQZ}, {Q1, C3_BNEZ}:
        exp = {b_imm[12], b_imm[10:5], 5'd0, rp_hi, 2'b00, i_c[13], b_imm[4:1], b_imm[11], OPC_BRANCH};
      {Q2, C3_SLLI}: begin
        ill = i_c[12];
        exp = r_type(7'b0, rs2, rd, 3'b001, rd, OPC_OP_IMM);
      end
      {Q2, C3_LWSP}: begin
        ill = (rd == 5'd0);
        exp = i_type(lwsp_imm, 5'd2, 3'b010, rd, OPC_LOAD);
      end
      {Q2, C3_JR_MV}: begin
        ill = !i_c[12] && (rs2 == 5'd0) && (rd == 5'd0);
        exp = (rs2 != 5'd0) ? r_type(7'b0, rs2, i_c[12] ? rd : 5'd0, 3'b000, rd, OPC_OP)
            : (i_c[12] && rd == 5'd0) ? INST_EBREAK
            : i_type(12'd0, rd, 3'b000, {4'd0, i_c[12]}, OPC_JALR);
      end
      {Q2, C3_SWSP}:     exp = s_type(swsp_imm, rs2, 5'd2, 3'b010, OPC_STORE);
      default:           ill = 1'b1;
    endcase
  end
  assign o_illegal = ill;
  assign o_inst = ill ? 32'h0 : exp;
endmodule

// File: rtl/decode_aligner.sv
// decode_aligner: halfword queue realigning fetch words into one expanded instruction per cycle
module decode_aligner
  import decode_aligner_pkg::*;
#(
  parameter int unsigned BUF_HW   = 6,
  parameter bit          C_EXT    = 1'b1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  input  logic        i_fetch_valid,
  output logic        o_fetch_ready,
  input  logic [31:0] i_fetch_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_c,
  output logic        o_inst_illegal
);
  localparam int PW = $clog2(BUF_HW);
  localparam int CW = $clog2(BUF_HW + 1);
  logic [15:0] q_q [BUF_HW];
  logic [15:0] q_d [BUF_HW];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic skip_q, skip_d;
  logic [15:0] h0, h1;
  logic is32, need2, avail, push, pop;
  logic [31:0] exp_inst;
  logic exp_ill;
  logic unused_ok;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_HW - 1)) ? '0 : p + 1'b1;
  endfunction
  assign unused_ok = i_flush_pc[0];
  assign head1 = inc(head_q);
  assign tail1 = inc(tail_q);
  assign h0 = q_q[head_q];
  assign h1 = q_q[head1];
  assign is32 = &h0[1:0];
  assign need2 = is32 || !C_EXT;
  assign avail = need2 ? (count_q >= CW'(2)) : (count_q != '0);
  assign o_fetch_ready = (count_q <= CW'(BUF_HW - 2)) && !i_flush;
  assign o_inst_valid = avail && !i_flush;
  assign push = i_fetch_valid && o_fetch_ready;
  assign pop = o_inst_valid && i_inst_ready;
  assign o_inst = need2 ? {h1, h0} : exp_inst;
  assign o_inst_pc = pc_q;
  assign o_inst_c = o_inst_valid && !need2;
  assign o_inst_illegal = o_inst_valid && !is32 && (exp_ill || !C_EXT);
  generate
    if (C_EXT) begin : g_rvc
      rvc_expander u_rvc (.i_c(h0), .o_inst(exp_inst), .o_illegal(exp_ill));
    end else begin : g_no_rvc
      assign exp_inst = '0;
      assign exp_ill  = 1'b0;
    end
  endgenerate
  // skip drops the low halfword of the first word after a redirect to a pc with bit 1 set
  always_comb begin
    q_d = q_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    pc_d = pc_q;
    skip_d = skip_q;
    if (i_flush) begin
      head_d = '0;
      tail_d = '0;
      count_d = '0;
      pc_d = {i_flush_pc[31:1], 1'b0};
      skip_d = i_flush_pc[1];
    end else begin
      if (push) begin
        q_d[tail_q] = skip_q ? i_fetch_data[31:16] : i_fetch_data[15:0];
        if (!skip_q) q_d[tail1] = i_fetch_data[31:16];
        tail_d = skip_q ? tail1 : inc(tail1);
        skip_d = 1'b0;
      end
      if (pop) begin
        head_d = need2 ? inc(head1) : head1;
        pc_d = pc_q + (need2 ? 32'd4 : 32'd2);
      end
      count_d = count_q + CW'(push ? (skip_q ? 1 : 2) : 0) - CW'(pop ? (need2 ? 2 : 1) : 0);
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      pc_q <= {RESET_PC[31:1], 1'b0};
      skip_q <= RESET_PC[1];
    end else begin
      q_q <= q_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      pc_q <= pc_d;
      skip_q <= skip_d;
    end
  end
endmodule

// File: tb/tb_decode_aligner.sv
// tb_decode_aligner: directed scoreboard bench for decode_aligner with and without RVC
module tb_decode_aligner;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] mask;
    logic [31:0] pc;
    logic c;
    logic ill;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic flush = 1'b0;
  logic [31:0] fpc = '0;
  logic fv = 1'b0, fr, v1, rdy1 = 1'b1, c1, ill1;
  logic [31:0] fd = '0, inst1, pc1;
  logic fv2 = 1'b0, fr2, v2, c2, ill2;
  logic [31:0] fd2 = '0, inst2, pc2;
  exp_t sb1[$];
  exp_t sb2[$];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  decode_aligner #(.BUF_HW(6), .C_EXT(1'b1), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_flush_pc(fpc),
    .i_fetch_valid(fv), .o_fetch_ready(fr), .i_fetch_data(fd),
    .o_inst_valid(v1), .i_inst_ready(rdy1), .o_inst(inst1), .o_inst_pc(pc1),
    .o_inst_c(c1), .o_inst_illegal(ill1));
  decode_aligner #(.BUF_HW(4), .C_EXT(1'b0), .RESET_PC(32'h0)) dut_noc (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0), .i_flush_pc(32'h0),
    .i_fetch_valid(fv2), .o_fetch_ready(fr2), .i_fetch_data(fd2),
    .o_inst_valid(v2), .i_inst_ready(1'b1), .o_inst(inst2), .o_inst_pc(pc2),
    .o_inst_c(c2), .o_inst_illegal(ill2));
  function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc, input logic c,
                              input logic ill, input logic [31:0] mask);
    exp_t e;
    e.inst = inst; e.pc = pc; e.c = c; e.ill = ill; e.mask = mask;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask
  task automatic cmp_item(input string nm, input exp_t e, input logic [31:0] inst, input logic [31:0] pc,
                          input logic c, input logic ill);
    n_cmp++;
    if ((((inst ^ e.inst) & e.mask) !== 32'h0) || pc !== e.pc || c !== e.c || ill !== e.ill) begin
      n_err++;
      $display("FAIL %s: got inst=%h pc=%h c=%b ill=%b, expected inst=%h(mask %h) pc=%h c=%b ill=%b",
               nm, inst, pc, c, ill, e.inst, e.mask, e.pc, e.c, e.ill);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && v1 && rdy1) begin
      if (sb1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut_unexpected: got inst=%h pc=%h, expected nothing", inst1, pc1);
      end else cmp_item("dut_inst", sb1.pop_front(), inst1, pc1, c1, ill1);
    end
    if (rst_n && v2) begin
      if (sb2.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL noc_unexpected: got inst=%h pc=%h, expected nothing", inst2, pc2);
      end else cmp_item("noc_inst", sb2.pop_front(), inst2, pc2, c2, ill2);
    end
  end
  task automatic feed(input logic [31:0] w);
    int n = 0;
    logic acc;
    fv = 1'b1; fd = w;
    do begin
      @(negedge clk); acc = fr;
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    fv = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL feed_timeout: word %h not accepted, expected accept", w);
    end
  endtask
  task automatic feed2(input logic [31:0] w);
    int n = 0;
    logic acc;
    fv2 = 1'b1; fd2 = w;
    do begin
      @(negedge clk); acc = fr2;
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    fv2 = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL feed2_timeout: word %h not accepted, expected accept", w);
    end
  endtask
  task automatic do_flush(input logic [31:0] tgt);
    flush = 1'b1; fpc = tgt;
    @(negedge clk);
    chk("flush_valid", {31'b0, v1}, 32'd0);
    chk("flush_ready", {31'b0, fr}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((sb1.size() != 0 || sb2.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (sb1.size() != 0 || sb2.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: pending %0d/%0d, expected 0/0", sb1.size(), sb2.size());
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", {31'b0, v1}, 32'd0);
    chk("reset_ready", {31'b0, fr}, 32'd1);
    chk("reset_pc", pc1, 32'h0);
    chk("reset_c_ill", {30'b0, c1, ill1}, 32'd0);
    @(posedge clk); #1;
    sb1.push_back(mk(32'h0000_0013, 32'h0, 1'b0, 1'b0, '1));
    sb1.push_back(mk(32'h0000_0513, 32'h4, 1'b1, 1'b0, '1));
    sb1.push_back(mk(32'h0010_0513, 32'h6, 1'b1, 1'b0, '1));
    feed(32'h0000_0013);
    feed(32'h4505_4501);
    wait_drain();
    do_flush(32'h0);
    sb1.push_back(mk(32'h0000_0513, 32'h0, 1'b1, 1'b0, '1));
    sb1.push_back(mk(32'h0000_0513, 32'h2, 1'b0, 1'b0, '1));
    sb1.push_back(mk(32'h0, 32'h6, 1'b1, 1'b1, 32'h3));
    feed(32'h0513_4501);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) chk("straddle_hold_valid", {31'b0, v1}, 32'd0);
      @(posedge clk); #1;
    end
    feed(32'h0000_0000);
    @(negedge clk);
    chk("straddle_valid_next", {31'b0, v1}, 32'd1);
    @(posedge clk); #1;
    wait_drain();
    sb1.push_back(mk(32'h0000_0013, 32'h102, 1'b0, 1'b0, '1));
    sb1.push_back(mk(32'h0, 32'h106, 1'b1, 1'b1, 32'h3));
    do_flush(32'h102);
    feed(32'h0013_4501);
    feed(32'h0000_0000);
    wait_drain();
    rdy1 = 1'b0;
    do_flush(32'h0);
    for (int i = 0; i < 8; i++) sb1.push_back(mk({i[11:0], 20'h00513}, 2 * i, 1'b1, 1'b0, '1));
    for (int i = 0; i < 3; i++) sb1.push_back(mk(32'h0000_0513, 32'h10 + 2 * i, 1'b1, 1'b0, '1));
    sb1.push_back(mk(32'h0000_0013, 32'h16, 1'b0, 1'b0, '1));
    sb1.push_back(mk(32'h0, 32'h1A, 1'b1, 1'b1, 32'h3));
    feed(32'h4505_4501);
    feed(32'h450D_4509);
    feed(32'h4515_4511);
    fv = 1'b1; fd = 32'h451D_4519;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("full_ready", {31'b0, fr}, 32'd0);
      @(posedge clk); #1;
    end
    fv = 1'b0;
    rdy1 = 1'b1;
    feed(32'h451D_4519);
    feed(32'h4501_4501);
    feed(32'h0013_4501);
    feed(32'h0000_0000);
    wait_drain();
    sb2.push_back(mk(32'h0, 32'h0, 1'b0, 1'b1, 32'h0));
    sb2.push_back(mk(32'h0000_0013, 32'h4, 1'b0, 1'b0, '1));
    sb2.push_back(mk(32'h0, 32'h8, 1'b0, 1'b1, 32'h0));
    feed2(32'h0000_0000);
    feed2(32'h0000_0013);
    feed2(32'h4501_4501);
    wait_drain();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end
endmodule
